// File: rtl/list_share_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// list_share_arbiter_pkg: shared FSM encoding and defaults (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package list_share_arbiter_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_RELEASE  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/list_share_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// list_share_arbiter_rr_pick: first pending port at or after rr_ptr (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module list_share_arbiter_rr_pick #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] pending_i,
  input  logic [IDX_W-1:0]     rr_ptr_i,
  output logic [IDX_W-1:0]     grant_o,
  output logic                 any_pending_o
);

  logic [IDX_W:0] cand;

  // Scan from the farthest offset down so the nearest pending port wins last.
  always_comb begin
    grant_o       = '0;
    any_pending_o = 1'b0;
    cand          = '0;
    for (int off = NUM_PORTS - 1; off >= 0; off--) begin
      cand = {1'b0, rr_ptr_i} + (IDX_W + 1)'(off);
      if (cand >= (IDX_W + 1)'(NUM_PORTS)) begin
        cand = cand - (IDX_W + 1)'(NUM_PORTS);
      end
      if (pending_i[cand[IDX_W-1:0]]) begin
        grant_o       = cand[IDX_W-1:0];
        any_pending_o = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/list_share_arbiter.sv
// ---------------------------------------------------------------------------
// list_share_arbiter: round-robin sharing of one lazy-list producer (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module list_share_arbiter
  import list_share_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int WIDTH     = DEFAULT_WIDTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       ready,
  output logic                       up_req,
  input  logic                       up_ack,
  input  logic [WIDTH-1:0]           up_value,
  input  logic                       up_value_valid,
  input  logic [NUM_PORTS-1:0]       rq_req,
  output logic [NUM_PORTS-1:0]       rq_ack,
  output logic [NUM_PORTS*WIDTH-1:0] rq_value,
  output logic [NUM_PORTS-1:0]       rq_value_valid
);

  localparam int                IDX_W    = $clog2(NUM_PORTS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_PORTS - 1);

  state_e                     state_q, state_d;
  logic                       up_req_q, up_req_d;
  logic [NUM_PORTS-1:0]       rq_ack_q, rq_ack_d;
  logic [NUM_PORTS*WIDTH-1:0] rq_value_q, rq_value_d;
  logic [NUM_PORTS-1:0]       rq_valid_q, rq_valid_d;
  logic [NUM_PORTS-1:0]       pending_q, pending_d;
  logic [NUM_PORTS-1:0]       last_req_q, last_req_d;
  logic [IDX_W-1:0]           rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]           grant_q, grant_d;
  logic                       exhausted_q, exhausted_d;

  logic [NUM_PORTS-1:0]       clr;
  logic [IDX_W-1:0]           pick_idx;
  logic                       pick_any;

  list_share_arbiter_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr_pick (
    .pending_i     (pending_q),
    .rr_ptr_i      (rr_ptr_q),
    .grant_o       (pick_idx),
    .any_pending_o (pick_any)
  );

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      up_req_q    <= 1'b0;
      rq_ack_q    <= '0;
      rq_value_q  <= '0;
      rq_valid_q  <= '0;
      pending_q   <= '0;
      last_req_q  <= '0;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      exhausted_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      up_req_q    <= up_req_d;
      rq_ack_q    <= rq_ack_d;
      rq_value_q  <= rq_value_d;
      rq_valid_q  <= rq_valid_d;
      pending_q   <= pending_d;
      last_req_q  <= last_req_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      exhausted_q <= exhausted_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    up_req_d    = up_req_q;
    rq_ack_d    = '0;
    rq_value_d  = rq_value_q;
    rq_valid_d  = rq_valid_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    exhausted_d = exhausted_q;
    last_req_d  = rq_req;
    clr         = '0;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          if (exhausted_q) begin
            // List already ended: answer end-of-list without touching upstream.
            rq_ack_d[pick_idx]   = 1'b1;
            rq_valid_d[pick_idx] = 1'b0;
            clr[pick_idx]        = 1'b1;
            rr_ptr_d             = next_idx(pick_idx);
          end else begin
            up_req_d = 1'b1;
            state_d  = ST_WAIT_ACK;
          end
        end
      end
      ST_WAIT_ACK: begin
        if (up_ack) begin
          rq_value_d[grant_q*WIDTH +: WIDTH] = up_value;
          rq_valid_d[grant_q]                = up_value_valid;
          rq_ack_d[grant_q]                  = 1'b1;
          clr[grant_q]                       = 1'b1;
          up_req_d                           = 1'b0;
          rr_ptr_d                           = next_idx(grant_q);
          if (!up_value_valid) begin
            exhausted_d = 1'b1;
          end
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new edge on the same cycle as a grant clear keeps the port pending.
    pending_d = (pending_q & ~clr) | (rq_req & ~last_req_q);

    if (!ready) begin
      state_d     = ST_IDLE;
      up_req_d    = 1'b0;
      rq_ack_d    = '0;
      rq_value_d  = '0;
      rq_valid_d  = '0;
      pending_d   = '0;
      last_req_d  = '0;
      rr_ptr_d    = '0;
      grant_d     = '0;
      exhausted_d = 1'b0;
    end
  end

  assign up_req         = up_req_q;
  assign rq_ack         = rq_ack_q;
  assign rq_value       = rq_value_q;
  assign rq_value_valid = rq_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_list_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_list_share_arbiter: directed + random bench with list-level reference model
// ---------------------------------------------------------------------------
`default_nettype none

module tb_list_share_arbiter;

  localparam int NP   = 2;
  localparam int W    = 8;
  localparam int MAXV = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              ready;
  logic              up_req;
  logic              up_ack;
  logic [W-1:0]      up_value;
  logic              up_value_valid;
  logic [NP-1:0]     rq_req;
  logic [NP-1:0]     rq_ack;
  logic [NP*W-1:0]   rq_value;
  logic [NP-1:0]     rq_value_valid;

  always #5 clock = ~clock;

  list_share_arbiter #(.NUM_PORTS(NP), .WIDTH(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .ready          (ready),
    .up_req         (up_req),
    .up_ack         (up_ack),
    .up_value       (up_value),
    .up_value_valid (up_value_valid),
    .rq_req         (rq_req),
    .rq_ack         (rq_ack),
    .rq_value       (rq_value),
    .rq_value_valid (rq_value_valid)
  );

  // Upstream BoundedEnum(min=0, step=1, max=2); up_stall delays its ack.
  logic up_last, up_armed, up_stall;
  int   up_cur;

  always @(posedge clock or posedge reset) begin
    if (reset || !ready) begin
      up_last <= 1'b0; up_armed <= 1'b0; up_ack <= 1'b0;
      up_value <= '0; up_value_valid <= 1'b0; up_cur <= 0;
    end else begin
      up_last <= up_req;
      up_ack  <= 1'b0;
      if ((up_armed || (up_req && !up_last)) && !up_stall) begin
        up_armed       <= 1'b0;
        up_ack         <= 1'b1;
        up_value       <= W'(up_cur);
        up_value_valid <= (up_cur <= MAXV);
        if (up_cur <= MAXV) up_cur <= up_cur + 1;
      end else if (up_req && !up_last) begin
        up_armed <= 1'b1;
      end
    end
  end

  // Reference model: the list is consumed in ack order, one element per ack.
  int            checks = 0;
  int            failures = 0;
  logic [NP-1:0] outstanding;
  int            age [NP];
  int            pos;
  bit            ended;
  logic [W-1:0]  mval [NP];
  logic          mvalid [NP];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    outstanding = '0;
    pos = 0;
    ended = 1'b0;
    for (int k = 0; k < NP; k++) begin
      age[k] = 0; mval[k] = '0; mvalid[k] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (!ready) begin
      model_clear();
      check("ack_while_not_ready", 32'(rq_ack), 32'(0));
      check("upreq_while_not_ready", 32'(up_req), 32'(0));
    end else begin
      check("ack_onehot", 32'($countones(rq_ack) <= 1), 32'(1));
      check("ack_unpended", 32'(rq_ack & ~outstanding), 32'(0));
      for (int k = 0; k < NP; k++) begin
        if (rq_ack[k] && outstanding[k]) begin
          if (ended) begin
            mvalid[k] = 1'b0;
          end else if (pos <= MAXV) begin
            mval[k] = W'(pos); mvalid[k] = 1'b1; pos++;
          end else begin
            mval[k] = W'(pos); mvalid[k] = 1'b0; ended = 1'b1;
          end
          outstanding[k] = 1'b0;
          age[k] = 0;
        end else if (outstanding[k]) begin
          age[k]++;
          if (age[k] > 40) begin
            check("ack_timeout", 32'(age[k]), 32'(0));
            outstanding[k] = 1'b0;
            age[k] = 0;
          end
        end
      end
      for (int k = 0; k < NP; k++) begin
        check("port_value", 32'(rq_value[k*W +: W]), 32'(mval[k]));
        check("port_valid", 32'(rq_value_valid[k]), 32'(mvalid[k]));
      end
      if (ended) check("upreq_after_end", 32'(up_req), 32'(0));
    end
  endtask

  task automatic raise(input int k);
    rq_req[k] = 1'b1;
    outstanding[k] = 1'b1;
  endtask

  task automatic wait_ack(input int k, input int exp_lat, input string tag);
    int lat;
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (rq_ack[k]) begin
        lat = i;
        break;
      end
    end
    check(tag, 32'(lat), 32'(exp_lat));
  endtask

  task automatic restart_list();
    ready = 1'b0; rq_req = '0;
    tick();
    ready = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b1; ready = 1'b0; rq_req = '0; up_stall = 1'b0;
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    check("rst_up_req", 32'(up_req), 32'(0));
    check("rst_rq_ack", 32'(rq_ack), 32'(0));
    check("rst_rq_value", 32'(rq_value), 32'(0));
    check("rst_rq_valid", 32'(rq_value_valid), 32'(0));
    reset = 1'b0; ready = 1'b1;
    tick(); tick();

    // Port 0 alone walks the whole list including end-of-list.
    for (int i = 0; i < 4; i++) begin
      raise(0);
      wait_ack(0, 4, "t1_latency");
      rq_req[0] = 1'b0;
      tick();
    end
    check("t1_end_valid", 32'(rq_value_valid[0]), 32'(0));

    // After the end, a request is answered directly with valid=0.
    raise(1);
    wait_ack(1, 2, "t4_exhausted_latency");
    rq_req[1] = 1'b0;
    tick(); tick();

    // Simultaneous requests, then port 0 re-requests while port 1 waits.
    restart_list();
    raise(0); raise(1);
    wait_ack(0, 4, "t2_p0_latency");
    rq_req[0] = 1'b0;
    tick();
    raise(0);
    wait_ack(1, 3, "t2_p1_latency");
    check("t2_p0_value_held", 32'(rq_value[W-1:0]), 32'(0));
    rq_req[1] = 1'b0;
    wait_ack(0, 4, "t3_p0_third");
    rq_req = '0;
    tick();

    // ready dropped during WAIT_ACK abandons the transaction.
    restart_list();
    raise(0);
    tick(); tick();
    check("t5_upreq_high", 32'(up_req), 32'(1));
    ready = 1'b0; rq_req = '0;
    tick();
    check("t5_upreq_dropped", 32'(up_req), 32'(0));
    ready = 1'b1;
    repeat (6) tick();
    raise(0);
    wait_ack(0, 4, "t5_after_restart");
    check("t5_value0", 32'(rq_value[W-1:0]), 32'(0));
    rq_req[0] = 1'b0;

    // Asynchronous reset in the middle of a stalled WAIT_ACK.
    up_stall = 1'b1;
    tick();
    raise(1);
    tick(); tick(); tick();
    check("t6_upreq_high", 32'(up_req), 32'(1));
    #3 reset = 1'b1;
    #1;
    check("t6_async_up_req", 32'(up_req), 32'(0));
    check("t6_async_rq_ack", 32'(rq_ack), 32'(0));
    check("t6_async_valid", 32'(rq_value_valid), 32'(0));
    model_clear();
    rq_req = '0; up_stall = 1'b0;
    #2 reset = 1'b0;
    tick(); tick();
    raise(1);
    wait_ack(1, 4, "t6_fresh_list");
    rq_req[1] = 1'b0;
    tick();

    // Random traffic with upstream stalls and occasional list restarts.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        restart_list();
      end else begin
        up_stall = ($urandom_range(0, 3) == 0);
        for (int k = 0; k < NP; k++) begin
          if (rq_req[k]) begin
            if ($urandom_range(0, 2) == 0) rq_req[k] = 1'b0;
          end else if (!outstanding[k] && $urandom_range(0, 3) == 0) begin
            raise(k);
          end
        end
        tick();
      end
    end
    up_stall = 1'b0;
    rq_req = '0;
    repeat (30) tick();
    check("drain_outstanding", 32'(outstanding), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
